// File: rtl/mfc_serial_if.sv
// Handshake and result bundle for the serial multi-function comparator.
// The master drives requests; the slave returns busy/done and results.
interface mfc_serial_if #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
);
  localparam int N = WIDTH / CHUNK;

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             eq;
  logic             ae;
  logic             gt;
  logic [N-1:0]     d;

  modport master (
    output start, A, B,
    input  busy, done, eq, ae, gt, d
  );

  modport slave (
    input  start, A, B,
    output busy, done, eq, ae, gt, d
  );
endinterface

// File: rtl/mfc_serial.sv
// Serial multi-function comparator: eq, |A|==|B|, gt and per-digit
// equality, computed LSB-first CHUNK bits per clock.
module mfc_serial #(
  parameter int WIDTH  = 16,
  parameter int CHUNK  = 4,
  parameter int SIGNED = 1
) (
  input  logic          clk,
  input  logic          rst,
  mfc_serial_if.slave   bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam bit SG = (SIGNED != 0);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] sa_q, sb_q;
  logic             sgn_a_q, sgn_b_q;
  logic             ca_q, cb_q;
  logic [CW-1:0]    cnt_q;
  logic             eq_acc_q, ae_acc_q, gt_acc_q;
  logic [N-1:0]     d_acc_q;
  logic             eq_q, ae_q, gt_q, done_q;
  logic [N-1:0]     d_q;

  logic [CHUNK-1:0] ch_a, ch_b;
  logic [CHUNK:0]   sum_a, sum_b;
  logic [CHUNK-1:0] mag_a, mag_b;
  logic             ca_n, cb_n;
  logic             ch_eq, last, accept;
  logic             eq_n, ae_n, gt_n;
  logic [N-1:0]     d_n;

  assign accept = (state_q == IDLE) && bus.start;
  assign last   = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (last)      state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_a  = sa_q[CHUNK-1:0];
    ch_b  = sb_q[CHUNK-1:0];
    ch_eq = (ch_a == ch_b);
    sum_a = {1'b0, ~ch_a} + {{CHUNK{1'b0}}, ca_q};
    sum_b = {1'b0, ~ch_b} + {{CHUNK{1'b0}}, cb_q};
    mag_a = ch_a;
    mag_b = ch_b;
    ca_n  = ca_q;
    cb_n  = cb_q;
    // Negative operands are negated on the fly to get their magnitude
    if (SG && sgn_a_q) begin
      mag_a = sum_a[CHUNK-1:0];
      ca_n  = sum_a[CHUNK];
    end
    if (SG && sgn_b_q) begin
      mag_b = sum_b[CHUNK-1:0];
      cb_n  = sum_b[CHUNK];
    end
    eq_n = eq_acc_q & ch_eq;
    ae_n = ae_acc_q & (mag_a == mag_b);
    gt_n = gt_acc_q;
    if (ch_a > ch_b)      gt_n = 1'b1;
    else if (ch_a < ch_b) gt_n = 1'b0;
    if (SG && last && (sgn_a_q != sgn_b_q))
      gt_n = ~sgn_a_q;
    d_n        = d_acc_q;
    d_n[cnt_q] = ch_eq;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sa_q     <= '0;
      sb_q     <= '0;
      sgn_a_q  <= 1'b0;
      sgn_b_q  <= 1'b0;
      ca_q     <= 1'b0;
      cb_q     <= 1'b0;
      cnt_q    <= '0;
      eq_acc_q <= 1'b0;
      ae_acc_q <= 1'b0;
      gt_acc_q <= 1'b0;
      d_acc_q  <= '0;
      eq_q     <= 1'b0;
      ae_q     <= 1'b0;
      gt_q     <= 1'b0;
      d_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        sa_q     <= bus.A;
        sb_q     <= bus.B;
        sgn_a_q  <= bus.A[WIDTH-1];
        sgn_b_q  <= bus.B[WIDTH-1];
        ca_q     <= 1'b1;
        cb_q     <= 1'b1;
        cnt_q    <= '0;
        eq_acc_q <= 1'b1;
        ae_acc_q <= 1'b1;
        gt_acc_q <= 1'b0;
        d_acc_q  <= '0;
      end else if (state_q == RUN) begin
        sa_q     <= sa_q >> CHUNK;
        sb_q     <= sb_q >> CHUNK;
        ca_q     <= ca_n;
        cb_q     <= cb_n;
        cnt_q    <= cnt_q + CW'(1);
        eq_acc_q <= eq_n;
        ae_acc_q <= ae_n;
        gt_acc_q <= gt_n;
        d_acc_q  <= d_n;
        if (last) begin
          eq_q   <= eq_n;
          ae_q   <= ae_n;
          gt_q   <= gt_n;
          d_q    <= d_n;
          done_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = done_q;
    bus.eq   = eq_q;
    bus.ae   = ae_q;
    bus.gt   = gt_q;
    bus.d    = d_q;
  end
endmodule

// File: tb/tb_mfc_serial.sv
// Directed bench for mfc_serial: signed and unsigned instances in lockstep.
module tb_mfc_serial;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   lat;

  always #5 clk = ~clk;

  mfc_serial_if #(.WIDTH(16), .CHUNK(4)) ifs ();
  mfc_serial_if #(.WIDTH(16), .CHUNK(4)) ifu ();

  mfc_serial #(.WIDTH(16), .CHUNK(4), .SIGNED(1)) u_s (
    .clk (clk),
    .rst (rst),
    .bus (ifs)
  );

  mfc_serial #(.WIDTH(16), .CHUNK(4), .SIGNED(0)) u_u (
    .clk (clk),
    .rst (rst),
    .bus (ifu)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st,
                       input logic [15:0] a,
                       input logic [15:0] b);
    ifs.start = st; ifs.A = a; ifs.B = b;
    ifu.start = st; ifu.A = a; ifu.B = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a request, return edges until done (bounded)
  task automatic do_op(input logic [15:0] a,
                       input logic [15:0] b,
                       output int n);
    drive(1'b1, a, b);
    step();
    drive(1'b0, 16'h0, 16'h0);
    n = 0;
    while (!ifs.done && n < 12) begin
      step();
      n++;
    end
  endtask

  initial begin
    drive(1'b0, 16'h0, 16'h0);
    #2;
    chk("rst_busy", ifs.busy, 0);
    chk("rst_done", ifs.done, 0);
    chk("rst_res", {ifs.eq, ifs.ae, ifs.gt, ifs.d}, 0);
    step();
    rst = 1'b1;
    step();

    // Equal operands; also check busy width
    drive(1'b1, 16'h1234, 16'h1234);
    step();
    drive(1'b0, 16'h0, 16'h0);
    lat = 0;
    while (ifs.busy && lat < 12) begin
      step();
      lat++;
    end
    chk("eq_busy_cyc", lat, 4);
    chk("eq_done", ifs.done, 1);
    chk("eq_res", {ifs.eq, ifs.ae, ifs.gt, ifs.d}, {3'b110, 4'b1111});
    step();
    chk("eq_done_pulse", ifs.done, 0);
    chk("eq_hold", {ifs.eq, ifs.d}, {1'b1, 4'b1111});

    // -2 vs 2: signed and unsigned views differ
    do_op(16'hFFFE, 16'h0002, lat);
    chk("neg2_lat", lat, 4);
    chk("neg2_s", {ifs.eq, ifs.ae, ifs.gt, ifs.d}, {3'b010, 4'b0000});
    chk("neg2_u_done", ifu.done, 1);
    chk("neg2_u", {ifu.eq, ifu.ae, ifu.gt, ifu.d}, {3'b001, 4'b0000});

    do_op(16'h0005, 16'hFF05, lat);
    chk("sgn_s", {ifs.eq, ifs.ae, ifs.gt, ifs.d}, {3'b001, 4'b0011});
    chk("sgn_u", {ifu.eq, ifu.ae, ifu.gt}, 3'b000);

    do_op(16'h8000, 16'h8000, lat);
    chk("min_min", {ifs.eq, ifs.ae, ifs.gt, ifs.d}, {3'b110, 4'b1111});

    do_op(16'h8000, 16'h7FFF, lat);
    chk("min_max", {ifs.eq, ifs.ae, ifs.gt, ifs.d}, {3'b000, 4'b0000});
    chk("min_max_u", {ifu.ae, ifu.gt}, 2'b01);

    do_op(16'h7FFF, 16'h8000, lat);
    chk("max_min", {ifs.eq, ifs.ae, ifs.gt}, 3'b001);
    chk("max_min_u", ifu.gt, 0);

    // Start while busy is dropped; start in done cycle is taken
    drive(1'b1, 16'h1234, 16'h1234);
    step();
    drive(1'b0, 16'h0, 16'h0);
    step();
    step();
    drive(1'b1, 16'h0000, 16'hFFFF);
    step();
    drive(1'b0, 16'h0, 16'h0);
    step();
    chk("ign_done", ifs.done, 1);
    chk("ign_res", {ifs.eq, ifs.ae, ifs.gt, ifs.d}, {3'b110, 4'b1111});
    drive(1'b1, 16'h0005, 16'hFF05);
    step();
    drive(1'b0, 16'h0, 16'h0);
    chk("b2b_busy", ifs.busy, 1);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_early", ifs.done, 0);
      step();
    end
    chk("b2b_early", ifs.done, 0);
    step();
    chk("b2b_done", ifs.done, 1);
    chk("b2b_res", {ifs.eq, ifs.ae, ifs.gt, ifs.d}, {3'b001, 4'b0011});

    // Get nonzero outputs, then reset mid-run between edges
    do_op(16'h8000, 16'h8000, lat);
    chk("pre_rst", {ifs.eq, ifs.d}, {1'b1, 4'b1111});
    drive(1'b1, 16'h7FFF, 16'h8000);
    step();
    drive(1'b0, 16'h0, 16'h0);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", ifs.busy, 0);
    chk("arst_done", ifs.done, 0);
    chk("arst_res", {ifs.eq, ifs.ae, ifs.gt, ifs.d}, 0);
    step();
    rst = 1'b1;
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ifs.done || ifs.busy) lat++;
    end
    chk("arst_quiet", lat, 0);
    do_op(16'h7FFF, 16'h8000, lat);
    chk("post_lat", lat, 4);
    chk("post_res", {ifs.eq, ifs.ae, ifs.gt, ifs.d}, {3'b001, 4'b0000});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
